ulpi_tx_link: RTL

Transmit-side ULPI link stage. It consumes the byte-wide AXI-S packet stream from the USB packet encoder (PID byte, payload and CRC, `tlast` on the final byte) and drives the ULPI PHY transmit protocol:
- a TXCMD carrying the PID,
- data bytes advanced by NXT,
- STP to end the packet.

It also handles bus turnaround, PHY receive preemption (DIR), stream underrun, and a minimum inter-packet gap.

---
 rtl/ulpi_tx_link.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ulpi_tx_link.sv
// Transmit-side ULPI link: turns the encoder byte stream into TXCMD, NXT-paced data and STP,
// handling PHY receive preemption, stream underrun and the inter-packet gap.
module ulpi_tx_link #(
  parameter int unsigned GAP = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_tvalid_i,
  output logic       tx_tready_o,
  input  logic       tx_tlast_i,
  input  logic [7:0] tx_tdata_i,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic       ulpi_stp_o,
  output logic [7:0] ulpi_data_o,
  output logic       busy_o,
  output logic       tx_done_o,
  output logic       tx_error_o
);

  typedef enum logic [2:0] {IDLE, TURN, CMD, DATA, STOP, DRAIN} state_t;

  // The STOP exit cycle already counts as the first gap cycle.
  localparam logic [3:0] GapLoad = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t     state_q, state_d;
  state_t     turnNext_q, turnNext_d;
  logic       turnOk_q, turnOk_d;
  logic [3:0] gapCnt_q, gapCnt_d;
  logic [3:0] pid_q, pid_d;
  logic       last_q, last_d;
  logic       stp_q, stp_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic       accept;

  function automatic logic [7:0] txCmd(input logic [3:0] pidNibble);
    return {4'b0100, pidNibble};
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      turnNext_q <= IDLE;
      turnOk_q   <= 1'b0;
      gapCnt_q   <= 4'd0;
      pid_q      <= 4'd0;
      last_q     <= 1'b0;
      stp_q      <= 1'b0;
      data_q     <= 8'h00;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      turnNext_q <= turnNext_d;
      turnOk_q   <= turnOk_d;
      gapCnt_q   <= gapCnt_d;
      pid_q      <= pid_d;
      last_q     <= last_d;
      stp_q      <= stp_d;
      data_q     <= data_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    turnNext_d = turnNext_q;
    turnOk_d   = turnOk_q;
    gapCnt_d   = gapCnt_q;
    pid_d      = pid_q;
    last_d     = last_q;
    stp_d      = 1'b0;
    data_d     = 8'h00;
    done_d     = 1'b0;
    error_d    = 1'b0;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        if (gapCnt_q != 4'd0) gapCnt_d = gapCnt_q - 4'd1;
        if (tx_tvalid_i && !ulpi_dir_i && gapCnt_q == 4'd0) begin
          accept  = 1'b1;
          pid_d   = tx_tdata_i[3:0];
          last_d  = tx_tlast_i;
          data_d  = txCmd(tx_tdata_i[3:0]);
          state_d = CMD;
        end
      end

      // DIR wins over a simultaneous NXT; only a preempted TXCMD is retried.
      CMD, DATA: begin
        data_d = data_q;
        if (ulpi_dir_i) begin
          data_d   = 8'h00;
          turnOk_d = 1'b0;
          state_d  = TURN;
          if (state_q == CMD) begin
            turnNext_d = CMD;
          end else begin
            error_d    = 1'b1;
            turnNext_d = last_q ? IDLE : DRAIN;
          end
        end else if (ulpi_nxt_i) begin
          if (last_q) begin
            stp_d   = 1'b1;
            data_d  = 8'h00;
            state_d = STOP;
          end else if (tx_tvalid_i) begin
            accept  = 1'b1;
            data_d  = tx_tdata_i;
            last_d  = tx_tlast_i;
            state_d = DATA;
          end else begin
            stp_d   = 1'b1;
            data_d  = 8'hFF;
            error_d = 1'b1;
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (ulpi_dir_i) begin
          error_d    = 1'b1;
          turnOk_d   = 1'b0;
          turnNext_d = last_q ? IDLE : DRAIN;
          state_d    = TURN;
        end else begin
          gapCnt_d = GapLoad;
          done_d   = last_q;
          state_d  = last_q ? IDLE : DRAIN;
        end
      end

      DRAIN: begin
        accept = tx_tvalid_i;
        if (tx_tvalid_i && tx_tlast_i) state_d = IDLE;
      end

      // Leave only after DIR has been low for one full turnaround cycle.
      TURN: begin
        if (ulpi_dir_i) begin
          turnOk_d = 1'b0;
        end else if (!turnOk_q) begin
          turnOk_d = 1'b1;
        end else begin
          turnOk_d = 1'b0;
          state_d  = turnNext_q;
          if (turnNext_q == CMD) data_d = txCmd(pid_q);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign tx_tready_o = accept && reset;
  assign ulpi_stp_o  = stp_q;
  assign ulpi_data_o = data_q;
  assign busy_o      = (state_q != IDLE);
  assign tx_done_o   = done_q;
  assign tx_error_o  = error_q;

endmodule
